// File: rtl/gate_exerciser.sv
// Stimulus driver / response checker for 2-input gates: sweeps {a,b} through 00..11, samples y, counts mismatches.
// Optional first-fail capture ports enabled by defining GATE_EXERCISER_FAIL_CAPTURE_EN.
module gate_exerciser #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             clr,
    input  logic [2:0]       gate_sel,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
`ifdef GATE_EXERCISER_FAIL_CAPTURE_EN
    ,
    output logic [1:0]       fail_vec,
    output logic             fail_valid
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0]       SETTLE_C = 8'(SETTLE);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t     state;
    logic [2:0] sel_q;
    logic [1:0] vec;
    logic [7:0] cnt;
    logic       failed;
    logic       expected;
    logic       sample;
    logic       mismatch;

    assign a = vec[1];
    assign b = vec[0];

    // NOTE: expected gets a default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        expected = vec[1] & vec[0];
        case (sel_q)
            3'd1:    expected = vec[1] | vec[0];
            3'd2:    expected = vec[1] ^ vec[0];
            3'd3:    expected = ~(vec[1] & vec[0]);
            3'd4:    expected = ~(vec[1] | vec[0]);
            3'd5:    expected = ~(vec[1] ^ vec[0]);
            default: expected = vec[1] & vec[0];
        endcase
    end

    // An abort in the sampling cycle suppresses the sample entirely.
    assign sample   = (state == RUN) && !abort && (cnt == SETTLE_C);
    assign mismatch = sample && (y != expected);

    // NOTE: all state here is sequential, so every assignment is non-blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= 3'd0;
            vec     <= 2'd0;
            cnt     <= 8'd0;
            failed  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state  <= RUN;
                        sel_q  <= gate_sel;
                        vec    <= 2'd0;
                        cnt    <= 8'd0;
                        failed <= 1'b0;
                        busy   <= 1'b1;
                        pass   <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        vec   <= 2'd0;
                        cnt   <= 8'd0;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (sample) begin
                        cnt <= 8'd0;
                        if (mismatch) failed <= 1'b1;
                        if (vec == 2'd3) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= !(failed || mismatch);
                            vec   <= 2'd0;
                        end else begin
                            vec <= vec + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // clr takes priority over a coincident mismatch increment.
            if (clr)
                err_cnt <= '0;
            else if (mismatch && (err_cnt != ERR_MAX))
                err_cnt <= err_cnt + ERR_W'(1);
        end
    end

`ifdef GATE_EXERCISER_FAIL_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_vec   <= 2'd0;
            fail_valid <= 1'b0;
        end else if (clr) begin
            fail_vec   <= 2'd0;
            fail_valid <= 1'b0;
        end else if (mismatch && !fail_valid) begin
            fail_vec   <= vec;
            fail_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/gate_exerciser.md
# gate_exerciser

Sequential stimulus driver and response checker for the team's 2-input combinational gates. On a start pulse it sweeps the gate under test through all four input vectors, waits a programmable settle time per vector, samples the gate output, compares it with the selected truth table, and reports pass/fail with a cumulative error count. It sits at the input/output pins of a gate instance on the test bring-up board, driving the gate's `a`/`b` and reading its `y`.

## Interface
Parameters:
- `SETTLE`, default 2: extra wait cycles per vector before sampling `y`; range 0..255.
- `ERR_W`, default 8: width of `err_cnt`; must be at least 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a sweep; honoured only in IDLE.
- `abort`  in  1  terminates a sweep; return to IDLE.
- `clr`  in  1  synchronous clear of `err_cnt` and the fail capture.
- `gate_sel`  in  3  expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6 and 7 check as AND.
- `y`  in  1  output of the gate under test.
- `a`, `b`  out  1 each  registered stimulus to the gate under test.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass`  out  1  result of the last completed sweep; held until the next start.
- `err_cnt`  out  ERR_W  saturating mismatch count, cumulative across sweeps.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN on `start` with `abort` low:
  - latch `gate_sel`;
  - set vector index to 0 and the settle counter to 0;
  - clear an internal sweep-failed flag.
- Stimulus mapping: `{a,b}` = vector index; order is 00, 01, 10, 11.
- RUN: the settle counter counts 0..SETTLE.
  - At count SETTLE, sample `y` and compare it with f(a,b), where f is the latched function.
  - On mismatch: increment `err_cnt`, saturating at 2^ERR_W-1, and set the sweep-failed flag.
  - Then advance the vector index and reset the counter.
  - After vector 11 is sampled, go to DONE.
- DONE (one cycle):
  - `done`=1;
  - `pass` = not sweep-failed;
  - `a`,`b` return to 0;
  - next state IDLE.
- `abort` in RUN: next state IDLE; `a`,`b`=0; `pass`=0; no `done` pulse. Mismatches already counted are kept.
- `start` while RUN or DONE: ignored.
- `start` and `abort` in the same IDLE cycle: `abort` wins and the sweep does not start.
- `clr` in the same cycle as a mismatch sample: `clr` wins, so `err_cnt` becomes 0. The sweep-failed flag is still set.
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0; FSM state IDLE. The optional `fail_vec`=0 and `fail_valid`=0 (see Configuration).
- Reset mid-sweep: all outputs take their reset values immediately, without waiting for a clock edge.

## Timing
- `start` is sampled at edge E0.
- After E0: `busy`=1 and `{a,b}`=00.
- Each vector is held for SETTLE+1 cycles. `y` is sampled at the last edge of that window, which is SETTLE+1 edges after `a`/`b` change.
- After edge E0+4(SETTLE+1):
  - `done`=1 and `pass` is valid;
  - `busy` stays 1 during the DONE cycle;
  - `busy` drops after the next edge.
- `err_cnt` updates at the sampling edge itself.
- Minimum interval between sweep starts: 4(SETTLE+1)+2 cycles.

## Configuration
- Macro: `GATE_EXERCISER_FAIL_CAPTURE_EN`.
- Defined: adds two output ports.
  - `fail_vec` (out, 2): the `{a,b}` of the first mismatch since reset or `clr`; held afterwards.
  - `fail_valid` (out, 1): set together with that capture.
  - Later mismatches do not overwrite the capture. `clr` clears both ports.
- Undefined: the ports and capture logic are absent; all other behaviour is identical.

## Test plan
- SETTLE=2, `gate_sel`=0, DUT `y`=a&b, pulse `start` -> `{a,b}`=00,01,10,11 for 3 cycles each; `done` pulse 12 cycles after the start edge; `pass`=1; `err_cnt`=0.
- `gate_sel`=1 (OR) with the DUT still AND -> mismatches at 01 and 10; `pass`=0; `err_cnt`=2; with the macro defined, `fail_vec`=01 and `fail_valid`=1.
- ERR_W=2, `y` tied to 1, `gate_sel`=0, two sweeps -> `err_cnt`=3 after the first sweep and stays 3 after the second; `clr` -> 0.
- `abort` at cycle 5 of a sweep -> `busy`=0 and `a`=`b`=0 the next cycle; no `done`; `pass`=0; a `start` at cycle 3 of the same sweep had no effect.
- `rst_n` low mid-sweep -> all outputs at reset values immediately, before any clock edge. Separately, `clr` coincident with a mismatch sample -> `err_cnt`=0, and the sweep still ends with `pass`=0.
- `gate_sel`=6 with the DUT AND -> `pass`=1 and `err_cnt`=0.
